// File: rtl/sys_bus_init_if.sv
// sys_bus_init_if: request, write-beat, AD bus and response signals of the
// SDRAM system-bus initiator. The initiator connects through the "master"
// modport. The requester and controller side uses "slave".
interface sys_bus_init_if;
  // requester -> initiator
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic        req_we;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  // initiator -> controller (multiplexed AD bus)
  logic [31:0] AD_o;
  logic        data_addr_n_o;
  logic        we_rn_o;
  // controller -> initiator
  logic        rd_valid_i;
  logic [31:0] rd_data_i;
  logic        cmd_done_i;
  // initiator -> requester
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        err;

  modport master (
    input  req_valid, req_cmd, req_we, req_addr, wr_valid, wr_data,
           rd_valid_i, rd_data_i, cmd_done_i,
    output req_ready, wr_ready, AD_o, data_addr_n_o, we_rn_o,
           rsp_valid, rsp_data, busy, err
  );

  modport slave (
    output req_valid, req_cmd, req_we, req_addr, wr_valid, wr_data,
           rd_valid_i, rd_data_i, cmd_done_i,
    input  req_ready, wr_ready, AD_o, data_addr_n_o, we_rn_o,
           rsp_valid, rsp_data, busy, err
  );
endinterface

// File: rtl/sys_bus_init.sv
// sys_bus_init: host-side initiator for the SDRAM controller AD bus.
// It accepts one request at a time and buffers all write beats first, so that
// the data phases go out back-to-back. It then drives address + data phases
// and forwards read beats back to the requester. It also keeps a shadow copy
// of the controller burst length.
// Optional feature: define SYS_BUS_INIT_TIMEOUT_EN to add a WAIT-state
// timeout. If the timeout expires, the initiator sets the sticky err flag and
// returns to IDLE.
module sys_bus_init #(
  parameter int BUF_DEPTH = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic          Clk_i,
  input  logic          Locked,
  sys_bus_init_if.master bus
);
  localparam int PW = (BUF_DEPTH < 8) ? 3 : $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addrw_q;            // address-phase word with cmd in [29:28]
  logic [1:0]      cmd_q;
  logic            wern_q;             // we_rn value for the address phase
  logic            wr_q;               // request carries write beats
  logic [CW-1:0]   n_q;
  logic [CW-1:0]   wcnt_q, wcnt_d;     // beats stored during FILL
  logic [CW-1:0]   rcnt_q, rcnt_d;     // beats issued during DATA
  logic [CW-1:0]   rleft_q, rleft_d;   // read beats still expected
  logic [2:0]      burst_sh_q, burst_sh_d;
  logic [31:0]     ad_q, ad_d;
  logic            dan_q, dan_d;
  logic            we_rn_q, we_rn_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            accept, wbuf_we;
  logic            is_wr_req, is_rd_req, req_wern;
  logic [CW-1:0]   n_req;
  logic [31:0]     req_word;
  logic [1:0]      unused_addr_bits;

  logic [31:0] wbuf [BUF_DEPTH];

  // The address-phase word replaces these address bits, so they are never needed
  assign unused_addr_bits = bus.req_addr[29:28];

  // Decode the incoming request: beat count, direction, and address word
  always_comb begin
    case (bus.req_cmd)
      2'b00:   n_req = CW'(burst_sh_q) + CW'(1);
      2'b10:   n_req = CW'(1);
      default: n_req = '0;
    endcase
    is_wr_req = ((bus.req_cmd == 2'b00) && bus.req_we) || (bus.req_cmd == 2'b10);
    is_rd_req = (bus.req_cmd == 2'b00) && !bus.req_we;
    req_wern  = (bus.req_cmd == 2'b00) ? bus.req_we : 1'b1;
    req_word  = {bus.req_addr[31:30], bus.req_cmd, bus.req_addr[27:0]};
  end

`ifdef SYS_BUS_INIT_TIMEOUT_EN
  logic [9:0] tmo_q;
  logic       err_q, err_d;

  // WAIT-cycle counter: it is zero on entry to WAIT and advances each WAIT cycle
  always_ff @(posedge Clk_i or negedge Locked) begin
    if (!Locked)                tmo_q <= '0;
    else if (state_q != S_WAIT) tmo_q <= '0;
    else                        tmo_q <= tmo_q + 10'd1;
  end

  // Sticky timeout flag
  always_ff @(posedge Clk_i or negedge Locked) begin
    if (!Locked) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  logic [9:0] unused_timeout;
  assign unused_timeout = 10'(TIMEOUT);
  assign bus.err        = 1'b0;
`endif

  // Next-state and registered-output logic. Bus outputs are computed one
  // cycle ahead so that they appear in the cycle of the state they belong to.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    rleft_d     = rleft_q;
    burst_sh_d  = burst_sh_q;
    ad_d        = ad_q;
    dan_d       = dan_q;
    we_rn_d     = we_rn_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    accept      = 1'b0;
    wbuf_we     = 1'b0;
`ifdef SYS_BUS_INIT_TIMEOUT_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          wcnt_d  = '0;
          rcnt_d  = '0;
          rleft_d = is_rd_req ? n_req : '0;
          if (is_wr_req) begin
            state_d = S_FILL;
          end else begin
            state_d = S_ADDR;
            ad_d    = req_word;
            dan_d   = 1'b0;
            we_rn_d = req_wern;
          end
        end
      end
      S_FILL: begin
        if (bus.wr_valid) begin
          wbuf_we = 1'b1;
          wcnt_d  = wcnt_q + CW'(1);
          if (wcnt_q + CW'(1) == n_q) begin
            state_d = S_ADDR;
            ad_d    = addrw_q;
            dan_d   = 1'b0;
            we_rn_d = wern_q;
          end
        end
      end
      S_ADDR: begin
        dan_d = 1'b1;
        if (wr_q) begin
          state_d = S_DATA;
          ad_d    = wbuf[0];
          we_rn_d = 1'b1;
          rcnt_d  = CW'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DATA: begin
        // The beat now on the bus programs the controller for cmd 10
        if (cmd_q == 2'b10) burst_sh_d = ad_q[6:4];
        if (rcnt_q == n_q) begin
          state_d = S_WAIT;
        end else begin
          ad_d   = wbuf[rcnt_q[PW-1:0]];
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (bus.rd_valid_i && (rleft_q != '0)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.rd_data_i;
          rleft_d     = rleft_q - CW'(1);
        end
        if (bus.cmd_done_i && (rleft_d == '0)) begin
          state_d = S_IDLE;
        end
`ifdef SYS_BUS_INIT_TIMEOUT_EN
        else if (tmo_q == 10'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, shadow burst length and registered outputs
  always_ff @(posedge Clk_i or negedge Locked) begin
    if (!Locked) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      rleft_q     <= '0;
      burst_sh_q  <= 3'b000;
      ad_q        <= '0;
      dan_q       <= 1'b1;
      we_rn_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      rleft_q     <= rleft_d;
      burst_sh_q  <= burst_sh_d;
      ad_q        <= ad_d;
      dan_q       <= dan_d;
      we_rn_q     <= we_rn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Latch the accepted request
  always_ff @(posedge Clk_i or negedge Locked) begin
    if (!Locked) begin
      addrw_q <= '0;
      cmd_q   <= 2'b00;
      wern_q  <= 1'b0;
      wr_q    <= 1'b0;
      n_q     <= '0;
    end else if (accept) begin
      addrw_q <= req_word;
      cmd_q   <= bus.req_cmd;
      wern_q  <= req_wern;
      wr_q    <= is_wr_req;
      n_q     <= n_req;
    end
  end

  // Write beat buffer, indexed by the fill count
  always_ff @(posedge Clk_i) begin
    if (wbuf_we) wbuf[wcnt_q[PW-1:0]] <= bus.wr_data;
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.wr_ready      = (state_q == S_FILL);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.AD_o          = ad_q;
  assign bus.data_addr_n_o = dan_q;
  assign bus.we_rn_o       = we_rn_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
endmodule

// File: tb/tb_sys_bus_init.sv
// tb_sys_bus_init: directed test of sys_bus_init. The timeout step is built
// only when SYS_BUS_INIT_TIMEOUT_EN is defined. The bench instantiates the
// design with TIMEOUT=16.
module tb_sys_bus_init;
  logic clk;
  logic locked;
  int   tests_run;
  int   tests_failed;

  sys_bus_init_if bus_if ();

  sys_bus_init #(
    .BUF_DEPTH(8),
    .TIMEOUT  (16)
  ) dut (
    .Clk_i (clk),
    .Locked(locked),
    .bus   (bus_if)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    locked               = 1'b0;
    bus_if.req_valid     = 1'b0;
    bus_if.req_cmd       = 2'b00;
    bus_if.req_we        = 1'b0;
    bus_if.req_addr      = '0;
    bus_if.wr_valid      = 1'b0;
    bus_if.wr_data       = '0;
    bus_if.rd_valid_i    = 1'b0;
    bus_if.rd_data_i     = '0;
    bus_if.cmd_done_i    = 1'b0;

    // ---- reset values ----
    tick(); tick();
    chk("rst_req_ready", bus_if.req_ready, 1);
    chk("rst_wr_ready", bus_if.wr_ready, 0);
    chk("rst_AD", bus_if.AD_o, 32'h0);
    chk("rst_dan", bus_if.data_addr_n_o, 1);
    chk("rst_we_rn", bus_if.we_rn_o, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_data", bus_if.rsp_data, 32'h0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_err", bus_if.err, 0);
    $display("[TB] reset checked");
    locked = 1'b1;
    tick();

    // ---- cmd 10: precharge + load control register, burst field = 1 ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b10; bus_if.req_we = 1'b0;
    bus_if.req_addr  = 32'h1234_5678;
    bus_if.wr_valid  = 1'b1; bus_if.wr_data = 32'h0070_321a;
    tick();
    bus_if.req_valid = 1'b0;
    chk("c10_fill_busy", bus_if.busy, 1);
    chk("c10_fill_req_ready", bus_if.req_ready, 0);
    chk("c10_fill_wr_ready", bus_if.wr_ready, 1);
    tick();
    bus_if.wr_valid = 1'b0;
    chk("c10_addr_AD", bus_if.AD_o, 32'h2234_5678);
    chk("c10_addr_dan", bus_if.data_addr_n_o, 0);
    chk("c10_addr_we_rn", bus_if.we_rn_o, 1);
    chk("c10_addr_wr_ready", bus_if.wr_ready, 0);
    tick();
    chk("c10_data_AD", bus_if.AD_o, 32'h0070_321a);
    chk("c10_data_dan", bus_if.data_addr_n_o, 1);
    chk("c10_data_we_rn", bus_if.we_rn_o, 1);
    tick();
    chk("c10_wait_AD_hold", bus_if.AD_o, 32'h0070_321a);
    chk("c10_wait_busy", bus_if.busy, 1);
    bus_if.cmd_done_i = 1'b1;
    tick();
    bus_if.cmd_done_i = 1'b0;
    chk("c10_idle_busy", bus_if.busy, 0);
    chk("c10_idle_req_ready", bus_if.req_ready, 1);
    $display("[TB] cmd10 load control register done");

    // ---- cmd 00 write, 2 beats (burst_sh=1) with gaps ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b00; bus_if.req_we = 1'b1;
    bus_if.req_addr  = 32'h0000_0100;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    chk("wr_gap_dan", bus_if.data_addr_n_o, 1);
    chk("wr_gap_wr_ready", bus_if.wr_ready, 1);
    bus_if.wr_valid = 1'b1; bus_if.wr_data = 32'hAAAA_0001;
    tick();
    bus_if.wr_valid = 1'b0;
    chk("wr_after_A_dan", bus_if.data_addr_n_o, 1);
    chk("wr_after_A_wr_ready", bus_if.wr_ready, 1);
    tick();
    bus_if.wr_valid = 1'b1; bus_if.wr_data = 32'hBBBB_0002;
    tick();
    bus_if.wr_valid = 1'b0;
    chk("wr_addr_AD", bus_if.AD_o, 32'h0000_0100);
    chk("wr_addr_dan", bus_if.data_addr_n_o, 0);
    chk("wr_addr_we_rn", bus_if.we_rn_o, 1);
    tick();
    chk("wr_beatA_AD", bus_if.AD_o, 32'hAAAA_0001);
    chk("wr_beatA_dan", bus_if.data_addr_n_o, 1);
    tick();
    chk("wr_beatB_AD", bus_if.AD_o, 32'hBBBB_0002);
    chk("wr_beatB_we_rn", bus_if.we_rn_o, 1);
    tick();
    chk("wr_wait_AD_hold", bus_if.AD_o, 32'hBBBB_0002);
    bus_if.cmd_done_i = 1'b1;
    tick();
    bus_if.cmd_done_i = 1'b0;
    chk("wr_idle_busy", bus_if.busy, 0);
    $display("[TB] cmd00 write 2 beats done");

    // ---- cmd 00 read, 2 beats, third beat dropped ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b00; bus_if.req_we = 1'b0;
    bus_if.req_addr  = 32'h0000_0200;
    tick();
    bus_if.req_valid = 1'b0;
    chk("rd_addr_AD", bus_if.AD_o, 32'h0000_0200);
    chk("rd_addr_dan", bus_if.data_addr_n_o, 0);
    chk("rd_addr_we_rn", bus_if.we_rn_o, 0);
    tick();
    chk("rd_wait_dan", bus_if.data_addr_n_o, 1);
    bus_if.rd_valid_i = 1'b1; bus_if.rd_data_i = 32'hD0D0_0001;
    tick();
    bus_if.rd_valid_i = 1'b0;
    chk("rd_rsp1_valid", bus_if.rsp_valid, 1);
    chk("rd_rsp1_data", bus_if.rsp_data, 32'hD0D0_0001);
    tick();
    chk("rd_gap_valid", bus_if.rsp_valid, 0);
    bus_if.rd_valid_i = 1'b1; bus_if.rd_data_i = 32'hD0D0_0002;
    tick();
    chk("rd_rsp2_valid", bus_if.rsp_valid, 1);
    chk("rd_rsp2_data", bus_if.rsp_data, 32'hD0D0_0002);
    bus_if.rd_data_i = 32'hD0D0_0003;
    tick();
    bus_if.rd_valid_i = 1'b0;
    chk("rd_extra_dropped", bus_if.rsp_valid, 0);
    chk("rd_extra_busy", bus_if.busy, 1);
    bus_if.cmd_done_i = 1'b1;
    tick();
    bus_if.cmd_done_i = 1'b0;
    chk("rd_idle_busy", bus_if.busy, 0);
    $display("[TB] cmd00 read 2 beats done");

    // ---- cmd 11 auto refresh ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b11; bus_if.req_we = 1'b0;
    bus_if.req_addr  = 32'h0000_0300;
    tick();
    bus_if.req_valid = 1'b0;
    chk("ref_addr_AD", bus_if.AD_o, 32'h3000_0300);
    chk("ref_addr_dan", bus_if.data_addr_n_o, 0);
    chk("ref_addr_we_rn", bus_if.we_rn_o, 1);
    tick();
    chk("ref_wait_dan", bus_if.data_addr_n_o, 1);
    tick();
    chk("ref_wait_AD_hold", bus_if.AD_o, 32'h3000_0300);
    chk("ref_wait_busy", bus_if.busy, 1);
    bus_if.cmd_done_i = 1'b1;
    tick();
    bus_if.cmd_done_i = 1'b0;
    chk("ref_idle_busy", bus_if.busy, 0);
    $display("[TB] cmd11 refresh done");

    // ---- reset during FILL after 1 of 2 beats ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b00; bus_if.req_we = 1'b1;
    bus_if.req_addr  = 32'h0000_0400;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.wr_valid = 1'b1; bus_if.wr_data = 32'hEEEE_0001;
    tick();
    bus_if.wr_valid = 1'b0;
    chk("abort_pre_wr_ready", bus_if.wr_ready, 1);
    locked = 1'b0;
    #1;
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_req_ready", bus_if.req_ready, 1);
    chk("abort_wr_ready", bus_if.wr_ready, 0);
    chk("abort_AD", bus_if.AD_o, 32'h0);
    chk("abort_dan", bus_if.data_addr_n_o, 1);
    chk("abort_we_rn", bus_if.we_rn_o, 0);
    tick();
    locked = 1'b1;
    tick();
    // burst_sh is back to 0, so this write has exactly one beat
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b00; bus_if.req_we = 1'b1;
    bus_if.req_addr  = 32'h0000_0500;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.wr_valid = 1'b1; bus_if.wr_data = 32'hF0F0_0005;
    tick();
    bus_if.wr_valid = 1'b0;
    chk("post_addr_AD", bus_if.AD_o, 32'h0000_0500);
    chk("post_addr_dan", bus_if.data_addr_n_o, 0);
    tick();
    chk("post_data_AD", bus_if.AD_o, 32'hF0F0_0005);
    tick();
    chk("post_wait_AD_hold", bus_if.AD_o, 32'hF0F0_0005);
    chk("post_wait_dan", bus_if.data_addr_n_o, 1);
    bus_if.cmd_done_i = 1'b1;
    tick();
    bus_if.cmd_done_i = 1'b0;
    chk("post_idle_busy", bus_if.busy, 0);
    $display("[TB] reset abort and single-beat write done");

`ifdef SYS_BUS_INIT_TIMEOUT_EN
    // ---- timeout: read with no cmd_done ----
    bus_if.req_valid = 1'b1; bus_if.req_cmd = 2'b00; bus_if.req_we = 1'b0;
    bus_if.req_addr  = 32'h0000_0600;
    tick();
    bus_if.req_valid = 1'b0;
    tick();   // first WAIT cycle
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_last_wait_busy", bus_if.busy, 1);
    chk("tmo_last_wait_err", bus_if.err, 0);
    tick();
    chk("tmo_err", bus_if.err, 1);
    chk("tmo_busy", bus_if.busy, 0);
    chk("tmo_req_ready", bus_if.req_ready, 1);
    tick();
    chk("tmo_err_sticky", bus_if.err, 1);
    $display("[TB] timeout done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
